// File: rtl/multi_cycle_rv_core.sv
// Multi-cycle RV integer ALU core: one ALU and one register file shared across
// FETCH/DECODE/EXECUTE/WRITEBACK, req/ready instruction fetch, halt on ECALL/illegal.
module multi_cycle_rv_core #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     REG_ADDR_W = 5,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [XLEN-1:0]       imem_addr_o,
    input  logic                  imem_ready_i,
    input  logic [31:0]           imem_instr_i,
    output logic                  retire_o,
    output logic [XLEN-1:0]       retire_pc_o,
    output logic [REG_ADDR_W-1:0] retire_rd_o,
    output logic [XLEN-1:0]       retire_data_o,
    output logic                  halted_o,
    output logic                  illegal_o,
    input  logic [REG_ADDR_W-1:0] dbg_raddr_i,
    output logic [XLEN-1:0]       dbg_rdata_o
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
    localparam int unsigned SHAMT_W  = $clog2(XLEN);
    localparam logic [6:0]  OP_IMM   = 7'h13;
    localparam logic [6:0]  OP_REG   = 7'h33;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [XLEN-1:0]       pc_q;
    logic [31:0]           ir_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    logic [XLEN-1:0]       alu_q;
    logic                  illegal_q;
    logic [XLEN-1:0]       rf [NUM_REGS];

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd_f;
    logic [4:0]            rs1_f;
    logic [4:0]            rs2_f;
    logic [REG_ADDR_W-1:0] rd_idx;
    logic [REG_ADDR_W-1:0] rs1_idx;
    logic [REG_ADDR_W-1:0] rs2_idx;
    logic                  is_ecall;
    logic                  is_imm;
    logic                  idx_ok;
    logic                  legal;
    logic [XLEN-1:0]       imm;
    logic [SHAMT_W-1:0]    shamt;
    logic [XLEN-1:0]       alu_res;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign rd_f    = ir_q[11:7];
    assign rs1_f   = ir_q[19:15];
    assign rs2_f   = ir_q[24:20];
    assign rd_idx  = ir_q[7 +: REG_ADDR_W];
    assign rs1_idx = ir_q[15 +: REG_ADDR_W];
    assign rs2_idx = ir_q[20 +: REG_ADDR_W];

    // Instruction classification and legality of the latched instruction word
    always_comb begin
        is_ecall = (ir_q == ECALL);
        is_imm   = (opcode == OP_IMM);
        imm      = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        idx_ok   = ((rd_f >> REG_ADDR_W) == 5'd0) && ((rs1_f >> REG_ADDR_W) == 5'd0);
        legal    = 1'b0;
        case (opcode)
            OP_REG: legal = idx_ok && ((rs2_f >> REG_ADDR_W) == 5'd0) &&
                            ((funct7 == 7'h00) ||
                             ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
            OP_IMM: begin
                case (funct3)
                    3'd1:    legal = idx_ok && (ir_q[31:20+SHAMT_W] == '0);
                    3'd5:    legal = idx_ok && !ir_q[31] && (ir_q[29:20+SHAMT_W] == '0);
                    default: legal = idx_ok;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Shared ALU; bit 30 selects SUB (register form only) and arithmetic right shift
    always_comb begin
        shamt   = b_q[SHAMT_W-1:0];
        alu_res = '0;
        case (funct3)
            3'd0:    alu_res = ((opcode == OP_REG) && ir_q[30]) ? (a_q - b_q) : (a_q + b_q);
            3'd1:    alu_res = a_q << shamt;
            3'd2:    alu_res = XLEN'($signed(a_q) < $signed(b_q));
            3'd3:    alu_res = XLEN'(a_q < b_q);
            3'd4:    alu_res = a_q ^ b_q;
            3'd5:    alu_res = ir_q[30] ? XLEN'($signed(a_q) >>> shamt) : (a_q >> shamt);
            3'd6:    alu_res = a_q | b_q;
            default: alu_res = a_q & b_q;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (imem_ready_i) state_d = S_DECODE;
            S_DECODE:    state_d = (is_ecall || !legal) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            default:     state_d = S_HALT;
        endcase
    end

    // Datapath registers: IR, operand latches, ALU result, PC and halt cause
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:   if (imem_ready_i) ir_q <= imem_instr_i;
                S_DECODE: begin
                    a_q <= rf[rs1_idx];
                    b_q <= is_imm ? imm : rf[rs2_idx];
                    if (!is_ecall && !legal) illegal_q <= 1'b1;
                end
                S_EXECUTE:   alu_q <= alu_res;
                S_WRITEBACK: pc_q  <= pc_q + XLEN'(4);
                default: ;
            endcase
        end
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if ((state_q == S_WRITEBACK) && (rd_idx != '0)) begin
            rf[rd_idx] <= alu_q;
        end
    end

    // Outputs decoded from registered state; req is held low while reset is applied
    assign imem_req_o    = (state_q == S_FETCH) && !rst_i;
    assign imem_addr_o   = pc_q;
    assign retire_o      = (state_q == S_WRITEBACK);
    assign retire_pc_o   = retire_o ? pc_q : '0;
    assign retire_rd_o   = retire_o ? rd_idx : '0;
    assign retire_data_o = retire_o ? alu_q : '0;
    assign halted_o      = (state_q == S_HALT);
    assign illegal_o     = illegal_q;
    assign dbg_rdata_o   = (dbg_raddr_i == '0) ? '0 : rf[dbg_raddr_i];

endmodule

// File: tb/tb_multi_cycle_rv_core.sv
// Scoreboard bench for multi_cycle_rv_core: a 32-bit and a 64-bit instance share one clock.
module tb_multi_cycle_rv_core;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
        int          cyc;
    } ret_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst32 = 1'b1;
    logic        rst64 = 1'b1;
    int          stall_until = 0;
    int          cyc32 = 0;
    int          cyc64 = 0;
    int          n32 = 0;
    int          total = 0;
    int          bad = 0;

    logic        req32, ready32, retire32, halted32, illegal32;
    logic [31:0] addr32, instr32, rpc32, rdata32, dbgd32;
    logic [4:0]  rrd32, dbg32;
    logic        req64, ready64, retire64, halted64, illegal64;
    logic [63:0] addr64, rpc64, rdata64, dbgd64;
    logic [31:0] instr64;
    logic [4:0]  rrd64, dbg64;
    logic        prev32 = 1'b0;
    logic        prev64 = 1'b0;

    logic [31:0] mem32 [64];
    logic [31:0] mem64 [64];
    ret_t        sb32[$];
    ret_t        sb64[$];
    chk_t        chk_q[$];
    chk_t        mc;
    ret_t        me;
    logic [31:0] ill_words [3];

    always #5 clk = ~clk;

    assign ready32 = !rst32 && (cyc32 > stall_until);
    assign ready64 = !rst64;
    assign instr32 = mem32[addr32[7:2]];
    assign instr64 = mem64[addr64[7:2]];

    // cycle number relative to reset release: the first cycle after release is 1
    always @(posedge clk) begin
        if (rst32) cyc32 <= 1; else cyc32 <= cyc32 + 1;
        if (rst64) cyc64 <= 1; else cyc64 <= cyc64 + 1;
    end

    multi_cycle_rv_core #(.XLEN(32), .REG_ADDR_W(5), .RESET_PC(32'h0)) dut32 (
        .clk_i(clk), .rst_i(rst32),
        .imem_req_o(req32), .imem_addr_o(addr32), .imem_ready_i(ready32), .imem_instr_i(instr32),
        .retire_o(retire32), .retire_pc_o(rpc32), .retire_rd_o(rrd32), .retire_data_o(rdata32),
        .halted_o(halted32), .illegal_o(illegal32), .dbg_raddr_i(dbg32), .dbg_rdata_o(dbgd32)
    );

    multi_cycle_rv_core #(.XLEN(64), .REG_ADDR_W(5), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut64 (
        .clk_i(clk), .rst_i(rst64),
        .imem_req_o(req64), .imem_addr_o(addr64), .imem_ready_i(ready64), .imem_instr_i(instr64),
        .retire_o(retire64), .retire_pc_o(rpc64), .retire_rd_o(rrd64), .retire_data_o(rdata64),
        .halted_o(halted64), .illegal_o(illegal64), .dbg_raddr_i(dbg64), .dbg_rdata_o(dbgd64)
    );

    // Monitor: the only process that compares and steps the counters
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            mc = chk_q.pop_front();
            total++;
            if (mc.act !== mc.exp) begin
                bad++;
                $display("FAIL %s got=%h want=%h", mc.name, mc.act, mc.exp);
            end
        end
        if (!rst32 && retire32) begin
            total++;
            if (sb32.size() == 0) begin
                bad++;
                $display("FAIL retire32 unexpected pc=%h rd=%0d data=%h", rpc32, rrd32, rdata32);
            end else begin
                me = sb32.pop_front();
                if (prev32 || 64'(rpc32) !== me.pc || rrd32 !== me.rd || 64'(rdata32) !== me.data ||
                    (me.cyc >= 0 && cyc32 != me.cyc)) begin
                    bad++;
                    $display("FAIL retire32 got pc=%h rd=%0d data=%h cyc=%0d back2back=%0b want pc=%h rd=%0d data=%h cyc=%0d",
                             rpc32, rrd32, rdata32, cyc32, prev32, me.pc, me.rd, me.data, me.cyc);
                end
            end
        end
        if (!rst64 && retire64) begin
            total++;
            if (sb64.size() == 0) begin
                bad++;
                $display("FAIL retire64 unexpected pc=%h rd=%0d data=%h", rpc64, rrd64, rdata64);
            end else begin
                me = sb64.pop_front();
                if (prev64 || rpc64 !== me.pc || rrd64 !== me.rd || rdata64 !== me.data ||
                    (me.cyc >= 0 && cyc64 != me.cyc)) begin
                    bad++;
                    $display("FAIL retire64 got pc=%h rd=%0d data=%h cyc=%0d want pc=%h rd=%0d data=%h cyc=%0d",
                             rpc64, rrd64, rdata64, cyc64, me.pc, me.rd, me.data, me.cyc);
                end
            end
        end
        prev32 = retire32;
        prev64 = retire64;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic void push32(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] data, input int cyc);
        ret_t r;
        r.pc = pc; r.rd = rd; r.data = data; r.cyc = cyc;
        sb32.push_back(r);
    endfunction

    function automatic void clear32();
        for (int i = 0; i < 64; i++) mem32[i] = ECALL;
        n32 = 0;
    endfunction

    // Place an instruction at the next word; with no stalls it retires at cycle 4*(n+1)
    function automatic void add32(input logic [31:0] instr, input logic [4:0] rd, input logic [31:0] exp);
        mem32[n32] = instr;
        push32(64'(n32 * 4), rd, 64'(exp), 4 * n32 + 4);
        n32++;
    endfunction

    task automatic do_reset(input bit w64);
        @(negedge clk);
        if (w64) rst64 = 1'b1; else rst32 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (w64) begin
            check("rst64_req", 64'(req64), 64'd0);
            check("rst64_halted", 64'(halted64), 64'd0);
            rst64 = 1'b0;
            #1;
            check("rel64_req", 64'(req64), 64'd1);
            check("rel64_addr", addr64, 64'hFFFF_FFFF_FFFF_FFFC);
        end else begin
            check("rst32_req", 64'(req32), 64'd0);
            check("rst32_retire", 64'(retire32), 64'd0);
            check("rst32_halted", 64'(halted32), 64'd0);
            check("rst32_illegal", 64'(illegal32), 64'd0);
            rst32 = 1'b0;
            #1;
            check("rel32_req", 64'(req32), 64'd1);
            check("rel32_addr", 64'(addr32), 64'd0);
        end
    endtask

    task automatic wait_halt(input bit w64, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (w64 ? halted64 : halted32) break;
            @(negedge clk);
        end
        check(w64 ? "halt64" : "halt32", 64'(w64 ? halted64 : halted32), 64'd1);
    endtask

    task automatic dbg_check32(input string name, input logic [4:0] idx, input logic [31:0] exp);
        dbg32 = idx;
        #1;
        check(name, 64'(dbgd32), 64'(exp));
    endtask

    initial begin
        dbg32 = '0;
        dbg64 = '0;
        for (int i = 0; i < 64; i++) mem64[i] = ECALL;

        // addi/addi/add, four cycles per instruction
        clear32();
        add32(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 5'd1, 32'd5);
        add32(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 5'd2, 32'hFFFF_FFFD);
        add32(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 5'd3, 32'd2);
        do_reset(1'b0);
        wait_halt(1'b0, 100);
        check("t1_illegal", 64'(illegal32), 64'd0);
        dbg_check32("t1_x3", 5'd3, 32'd2);
        dbg_check32("t1_x0", 5'd0, 32'd0);

        // five wait states on the first fetch; req/addr held steady
        clear32();
        mem32[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
        push32(64'd0, 5'd1, 64'd5, 9);
        stall_until = 5;
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) begin
            check("t2_req_hold", 64'(req32), 64'd1);
            check("t2_addr_hold", 64'(addr32), 64'd0);
            @(negedge clk);
        end
        wait_halt(1'b0, 100);
        stall_until = 0;

        // ALU coverage, including rd==rs1==rs2 at the end
        clear32();
        add32(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 5'd1, 32'd5);
        add32(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 5'd2, 32'hFFFF_FFFD);
        add32(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4), 5'd4, 32'hFFFF_FFF8);
        add32(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5), 5'd5, 32'd1);
        add32(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6), 5'd6, 32'd0);
        add32(enc_i(12'h401, 5'd2, 3'd5, 5'd7), 5'd7, 32'hFFFF_FFFE);
        add32(enc_i(12'h0F0, 5'd2, 3'd4, 5'd8), 5'd8, 32'hFFFF_FF0D);
        add32(enc_i(12'd28, 5'd2, 3'd5, 5'd9), 5'd9, 32'h0000_000F);
        add32(enc_r(7'h00, 5'd1, 5'd1, 3'd1, 5'd10), 5'd10, 32'h0000_00A0);
        add32(enc_i(12'hFFF, 5'd1, 3'd3, 5'd11), 5'd11, 32'd1);
        add32(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd12), 5'd12, 32'hFFFF_FFFD);
        add32(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd13), 5'd13, 32'd5);
        add32(enc_i(12'hFFE, 5'd2, 3'd2, 5'd14), 5'd14, 32'd1);
        add32(enc_r(7'h20, 5'd1, 5'd2, 3'd5, 5'd15), 5'd15, 32'hFFFF_FFFF);
        add32(enc_r(7'h00, 5'd1, 5'd2, 3'd5, 5'd16), 5'd16, 32'h07FF_FFFF);
        add32(enc_i(12'h7FF, 5'd2, 3'd7, 5'd17), 5'd17, 32'h0000_07FD);
        add32(enc_i(12'hFF0, 5'd1, 3'd6, 5'd18), 5'd18, 32'hFFFF_FFF5);
        add32(enc_i(12'd31, 5'd1, 3'd1, 5'd19), 5'd19, 32'h8000_0000);
        add32(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd20), 5'd20, 32'hFFFF_FFF8);
        add32(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd21), 5'd21, 32'd0);
        add32(enc_i(12'd1, 5'd1, 3'd0, 5'd1), 5'd1, 32'd6);
        add32(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd1), 5'd1, 32'd12);
        do_reset(1'b0);
        wait_halt(1'b0, 200);
        dbg_check32("t3_x4", 5'd4, 32'hFFFF_FFF8);
        dbg_check32("t3_x7", 5'd7, 32'hFFFF_FFFE);
        dbg_check32("t3_x1", 5'd1, 32'd12);

        // write to x0 is dropped, then an illegal word halts with the cause flag
        clear32();
        add32(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 5'd0, 32'd7);
        mem32[1] = 32'hFFFF_FFFF;
        do_reset(1'b0);
        wait_halt(1'b0, 100);
        check("t4_illegal", 64'(illegal32), 64'd1);
        dbg_check32("t4_x0", 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_req_low", 64'(req32), 64'd0);
        check("t4_still_halted", 64'(halted32), 64'd1);
        check("t4_addr_held", 64'(addr32), 64'd4);

        // more illegal encodings: slli with bit 30, and with funct7=0x20, a load opcode
        ill_words[0] = enc_i(12'h401, 5'd1, 3'd1, 5'd5);
        ill_words[1] = enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd3);
        ill_words[2] = 32'h0000_2083;
        for (int i = 0; i < 3; i++) begin
            clear32();
            mem32[0] = ill_words[i];
            do_reset(1'b0);
            wait_halt(1'b0, 50);
            check("t4b_illegal", 64'(illegal32), 64'd1);
        end

        // ECALL halts without the illegal flag
        clear32();
        do_reset(1'b0);
        wait_halt(1'b0, 50);
        check("t5_illegal", 64'(illegal32), 64'd0);

        // reset asserted while the second instruction is in EXECUTE
        clear32();
        mem32[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
        mem32[1] = enc_i(12'd9, 5'd0, 3'd0, 5'd2);
        push32(64'd0, 5'd1, 64'd5, 4);
        do_reset(1'b0);
        for (int i = 0; i < 50 && cyc32 != 7; i++) @(negedge clk);
        check("t5_reach_exec", 64'(cyc32), 64'd7);
        check("t5_exec_req", 64'(req32), 64'd0);
        rst32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_req", 64'(req32), 64'd0);
        dbg_check32("t5_x1_cleared", 5'd1, 32'd0);
        rst32 = 1'b0;
        #1;
        check("t5_refetch_req", 64'(req32), 64'd1);
        check("t5_refetch_addr", 64'(addr32), 64'd0);
        check("t5_not_halted", 64'(halted32), 64'd0);
        push32(64'd0, 5'd1, 64'd5, 4);
        push32(64'd4, 5'd2, 64'd9, 8);
        wait_halt(1'b0, 100);
        dbg_check32("t5_x2", 5'd2, 32'd9);

        // 64-bit instance: PC wraps past the top, wide shift
        mem64[63] = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
        mem64[0]  = enc_i(12'd40, 5'd1, 3'd1, 5'd2);
        begin
            ret_t r;
            r.pc = 64'hFFFF_FFFF_FFFF_FFFC; r.rd = 5'd1; r.data = 64'd1; r.cyc = 4;
            sb64.push_back(r);
            r.pc = 64'd0; r.rd = 5'd2; r.data = 64'h0000_0100_0000_0000; r.cyc = 8;
            sb64.push_back(r);
        end
        do_reset(1'b1);
        for (int i = 0; i < 50 && cyc64 != 5; i++) @(negedge clk);
        check("t6_wrap_req", 64'(req64), 64'd1);
        check("t6_wrap_addr", addr64, 64'd0);
        wait_halt(1'b1, 100);
        check("t6_illegal", 64'(illegal64), 64'd0);
        dbg64 = 5'd2;
        #1;
        check("t6_x2", dbgd64, 64'h0000_0100_0000_0000);

        check("sb32_empty", 64'(sb32.size()), 64'd0);
        check("sb64_empty", 64'(sb64.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
